// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch front-end bus: imem request/response, branch redirect, decode handshake
interface fetch_queue_if;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    // master: the fetch queue itself
    modport master (
        output imem_addr, imem_en, instr, instr_pc, instr_valid,
        input  imem_data, branch_taken, branch_target, stall
    );

    // slave: memory, execute and decode around the fetch queue
    modport slave (
        input  imem_addr, imem_en, instr, instr_pc, instr_valid,
        output imem_data, branch_taken, branch_target, stall
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC owner, credit-based imem fetch, {word,pc} FIFO to decode; optional FETCH_BYPASS_EN
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    typedef logic [OCC_W-1:0] occ_t;

    logic [31:0]      fetch_pc;
    logic             inflight;
    logic [31:0]      inflight_pc;
    logic [31:0]      mem_word [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             head_valid;
    logic             bypass;
    logic             pop;
    logic             pop_fifo;
    logic             push;
    logic             credit;
    occ_t             occ;

    // A response landing in an empty queue may be handed straight to decode
`ifdef FETCH_BYPASS_EN
    assign bypass = (count == '0) & inflight & ~bus.branch_taken;
`else
    assign bypass = 1'b0;
`endif

    // Head selection, handshake and issue credit
    always_comb begin
        head_valid = (count != '0);
        bus.instr_valid = head_valid | bypass;
        if (head_valid) begin
            bus.instr    = mem_word[rd_ptr];
            bus.instr_pc = mem_pc[rd_ptr];
        end else if (bypass) begin
            bus.instr    = bus.imem_data;
            bus.instr_pc = inflight_pc;
        end else begin
            bus.instr    = 32'h0;
            bus.instr_pc = 32'h0;
        end
        pop      = bus.instr_valid & ~bus.stall & ~bus.branch_taken;
        pop_fifo = pop & head_valid;
        // a bypassed word that decode takes never occupies a slot
        push     = inflight & ~bus.branch_taken & ~(bypass & pop);
        // slots already promised (buffered + in flight) minus the one leaving now
        occ      = occ_t'(count) + occ_t'(inflight);
        credit   = occ < (occ_t'(DEPTH) + occ_t'(pop));
        bus.imem_en   = bus.branch_taken | credit;
        bus.imem_addr = bus.branch_taken ? bus.branch_target : fetch_pc;
    end

    // PC, in-flight tracking and FIFO storage; a branch flushes everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_word[i] <= 32'h0;
                mem_pc[i]   <= 32'h0;
            end
        end else if (bus.branch_taken) begin
            fetch_pc    <= bus.branch_target + PC_INC;
            inflight    <= 1'b1;
            inflight_pc <= bus.branch_target;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (push) begin
                mem_word[wr_ptr] <= bus.imem_data;
                mem_pc[wr_ptr]   <= inflight_pc;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop_fifo) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count + CNT_W'(push) - CNT_W'(pop_fifo);
            inflight <= bus.imem_en;
            if (bus.imem_en) begin
                fetch_pc    <= fetch_pc + PC_INC;
                inflight_pc <= fetch_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with request-order reference model
module tb_fetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] key;
    logic [31:0] mem_q;
    int          checks = 0;
    int          failures = 0;

    fetch_queue_if bus();

    fetch_queue #(.RESET_PC(RESET_PC), .PC_INC(32'd4), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // synchronous instruction memory: word = address ^ key
    always @(posedge clk) begin
        if (bus.imem_en) mem_q <= bus.imem_addr ^ key;
    end
    assign bus.imem_data = mem_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every request, in order, until decode takes it or a branch/reset drops it
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        int          cyc;
    } req_t;
    req_t        pend[$];
    logic [31:0] model_pc;
    int          cyc = 0;

    always @(negedge clk) begin
        bit exp_valid;
        bit exp_pop;
        bit exp_en;
        if (!reset) begin
            check("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
            check("rst_instr", bus.instr, 32'h0);
            check("rst_pc", bus.instr_pc, 32'h0);
            check("rst_en", {31'b0, bus.imem_en}, 32'd1);
            check("rst_addr", bus.imem_addr, RESET_PC);
            pend.delete();
            model_pc = RESET_PC;
        end else begin
            exp_valid = (pend.size() > 0) && (pend[0].cyc + LAT <= cyc);
            check("valid", {31'b0, bus.instr_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                check("instr", bus.instr, pend[0].word);
                check("instr_pc", bus.instr_pc, pend[0].pc);
            end
            exp_pop = exp_valid && !bus.stall && !bus.branch_taken;
            exp_en  = bus.branch_taken || ((pend.size() - int'(exp_pop)) < DEPTH);
            check("imem_en", {31'b0, bus.imem_en}, {31'b0, exp_en});
            if (exp_en) begin
                check("imem_addr", bus.imem_addr, bus.branch_taken ? bus.branch_target : model_pc);
            end
            if (bus.branch_taken) begin
                pend.delete();
                pend.push_back('{pc: bus.branch_target, word: bus.branch_target ^ key, cyc: cyc});
                model_pc = bus.branch_target + 32'd4;
            end else begin
                if (exp_pop) void'(pend.pop_front());
                if (exp_en) begin
                    pend.push_back('{pc: model_pc, word: model_pc ^ key, cyc: cyc});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
        cyc++;
    end

    task automatic drive_next();
        @(posedge clk);
        #1;
    endtask

    task automatic branch_to(input logic [31:0] tgt, input logic stl,
                             input string nm, input logic [31:0] pc0, input logic [31:0] pc1);
        drive_next();
        bus.branch_taken  = 1'b1;
        bus.branch_target = tgt;
        bus.stall         = stl;
        drive_next();
        bus.branch_taken = 1'b0;
        bus.stall        = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k == LAT) begin
                check({nm, "_valid"}, {31'b0, bus.instr_valid}, 32'd1);
                check({nm, "_pc0"}, bus.instr_pc, pc0);
            end
            if (k == LAT + 1) check({nm, "_pc1"}, bus.instr_pc, pc1);
        end
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] pat;
        reset             = 1'b0;
        key               = 32'h0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        repeat (3) @(negedge clk);

        // out of reset: addresses 0,4,...; first word valid two cycles after the first request
        drive_next();
        reset = 1'b1;
        @(negedge clk);
        check("a_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("a_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        check("b_valid", {31'b0, bus.instr_valid}, {31'b0, LAT == 1});
        check("b_addr", bus.imem_addr, 32'h4);
        @(negedge clk);
        check("c_valid", {31'b0, bus.instr_valid}, 32'd1);
        check("c_pc", bus.instr_pc, (LAT == 2) ? 32'h0 : 32'h4);
        check("c_instr", bus.instr, (LAT == 2) ? 32'h0 : 32'h4);
        @(negedge clk);
        check("d_pc", bus.instr_pc, (LAT == 2) ? 32'h4 : 32'h8);
        repeat (4) @(negedge clk);

        // stall for 5 cycles: head held, fetch throttled
        drive_next();
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) held = bus.instr;
            else check("stall_hold", bus.instr, held);
            if (i == 4) check("stall_en", {31'b0, bus.imem_en}, 32'd0);
        end
        drive_next();
        bus.stall = 1'b0;
        repeat (3) @(negedge clk);

        branch_to(32'h0000_0100, 1'b0, "br100", 32'h100, 32'h104);
        repeat (2) @(negedge clk);

        // branch together with stall while the head is valid
        drive_next();
        bus.stall = 1'b1;
        branch_to(32'h0000_0040, 1'b1, "br40", 32'h40, 32'h44);

        branch_to(32'hFFFF_FFFC, 1'b0, "wrap", 32'hFFFF_FFFC, 32'h0);
        repeat (3) @(negedge clk);

        // patterned stall with one redirect in the middle
        pat = 32'b1011_0010_0111_0001_1100_1010_0110_1101;
        for (int i = 0; i < 32; i++) begin
            drive_next();
            bus.stall        = pat[i];
            bus.branch_taken = (i == 17);
            bus.branch_target = 32'h0000_2000;
        end
        drive_next();
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        repeat (3) @(negedge clk);

        // asynchronous reset mid-stream, then restart with a different memory pattern
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_valid", {31'b0, bus.instr_valid}, 32'd0);
        key = 32'hA5A5_0000;
        repeat (2) @(negedge clk);
        drive_next();
        reset = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 0) check("rst2_addr", bus.imem_addr, RESET_PC);
            if (k == LAT) begin
                check("rst2_valid", {31'b0, bus.instr_valid}, 32'd1);
                check("rst2_pc", bus.instr_pc, 32'h0);
                check("rst2_instr", bus.instr, 32'hA5A5_0000);
            end
        end
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
